// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending purchase controller.
// Latency: n/a (types, constants and one pure function).
// Backpressure: n/a.
//
// Contents: FSM state enum, coin codes, credit width, coin-to-units mapping.

package vend_pkg;

   // Credit is counted in 5-unit coins; 3 bits caps it at 7 units.
   localparam int CREDIT_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,   // credit == 0
      ST_CREDIT   = 2'd1,   // credit > 0, waiting for sel/cancel/coins
      ST_DISPENSE = 2'd2,   // disp_req held, waiting for disp_ack
      ST_CHANGE   = 2'd3    // returning credit one unit per cycle
   } state_t;

   localparam logic [1:0] COIN_NONE = 2'b00;
   localparam logic [1:0] COIN_5    = 2'b01;
   localparam logic [1:0] COIN_10   = 2'b10;
   localparam logic [1:0] COIN_BAD  = 2'b11;

   // Unit value of a coin code; none and invalid codes are worth nothing.
   function automatic logic [1:0] coin_value(input logic [1:0] code);
      logic [1:0] val;
      val = 2'd0;
      case (code)
         COIN_5:  val = 2'd1;
         COIN_10: val = 2'd2;
         default: val = 2'd0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/vend_sequencer_coin_arbiter.sv
// coin_arbiter: validates two coin slots, round-robins on contention, checks overflow.
// Latency: acc/acc_val combinational from the coin inputs; rej_a/rej_b registered, 1 cycle.
// Backpressure: none; coins that cannot be taken are rejected with a one-cycle rej pulse.
//
// Ports: clk, rst (sync, active high); coin_a/coin_b coin codes; accept_en high when the
// sequencer can take credit; credit current credit; acc/acc_val accepted coin strobe and
// its unit value (0..2); rej_a/rej_b registered per-slot reject pulses.

module coin_arbiter
   import vend_pkg::*;
#(
   parameter int CREDIT_MAX = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin_a,
   input  logic [1:0]          coin_b,
   input  logic                accept_en,
   input  logic [CREDIT_W-1:0] credit,
   output logic                acc,
   output logic [1:0]          acc_val,
   output logic                rej_a,
   output logic                rej_b
);

   localparam logic [CREDIT_W:0] MAX_EXT = CREDIT_MAX[CREDIT_W:0];

   logic            ptr_a;     // 1: slot A wins the next contention
   logic            valid_a, valid_b;
   logic            contend;
   logic            win_a, win_b;
   logic [1:0]      win_val;
   logic [CREDIT_W:0] sum_ext;
   logic            fits;
   logic            rej_a_nxt, rej_b_nxt;

   always_comb begin
      valid_a = (coin_a == COIN_5) || (coin_a == COIN_10);
      valid_b = (coin_b == COIN_5) || (coin_b == COIN_10);

      // Arbitration (and the pointer toggle) only matters when credit can be taken.
      contend = accept_en && valid_a && valid_b;
      win_a   = valid_a && (!valid_b || ptr_a);
      win_b   = valid_b && !win_a;

      win_val = 2'd0;
      if (win_a) begin
         win_val = coin_value(coin_a);
      end else if (win_b) begin
         win_val = coin_value(coin_b);
      end

      // Overflow is judged on the winner only; the loser is rejected regardless.
      sum_ext = {1'b0, credit} + {{(CREDIT_W-1){1'b0}}, win_val};
      fits    = (sum_ext <= MAX_EXT);

      acc     = accept_en && (win_a || win_b) && fits;
      acc_val = acc ? win_val : 2'd0;

      // Any non-empty code that was not the accepted coin gets rejected.
      rej_a_nxt = (coin_a != COIN_NONE) && !(acc && win_a);
      rej_b_nxt = (coin_b != COIN_NONE) && !(acc && win_b);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_a <= 1'b1;
         rej_a <= 1'b0;
         rej_b <= 1'b0;
      end else begin
         rej_a <= rej_a_nxt;
         rej_b <= rej_b_nxt;
         if (contend) begin
            ptr_a <= !ptr_a;
         end
      end
   end

endmodule

// File: rtl/vend_sequencer.sv
// vend_sequencer: priced purchase controller with two coin slots, dispense handshake and change.
// Latency: coin->credit/rej 1 cycle; sel->disp_req 1 cycle; disp_ack->disp_req low 1 cycle.
// Backpressure: coins rejected while busy or on overflow; disp_req held until ack or timeout.
//
// Ports: clk, rst (sync, active high); coin_a/coin_b coin codes; rej_a/rej_b reject pulses;
// sel/cancel purchase and refund pulses; credit current units; disp_req/disp_ack dispense
// handshake; change_pulse one cycle per returned unit; busy in DISPENSE/CHANGE; fault sticky
// dispense timeout. Build macro VEND_CHANGE_EN enables the CHANGE state, cancel and refunds;
// without it leftover credit carries over to the next purchase.

module vend_sequencer
   import vend_pkg::*;
#(
   parameter int PRICE_UNITS = 3,
   parameter int CREDIT_MAX  = 7,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          coin_a,
   input  logic [1:0]          coin_b,
   output logic                rej_a,
   output logic                rej_b,
   input  logic                sel,
   input  logic                cancel,
   output logic [CREDIT_W-1:0] credit,
   output logic                disp_req,
   input  logic                disp_ack,
   output logic                change_pulse,
   output logic                busy,
   output logic                fault
);

   localparam int                  TMR_W   = 8;
   localparam logic [CREDIT_W-1:0] PRICE   = PRICE_UNITS[CREDIT_W-1:0];
   localparam logic [TMR_W-1:0]    TIMEOUT = ACK_TIMEOUT[TMR_W-1:0];

   state_t              state, state_nxt;
   logic [CREDIT_W-1:0] credit_nxt;
   logic [CREDIT_W-1:0] sum;      // credit after this cycle's accepted coin
   logic [CREDIT_W-1:0] rem;      // credit left after paying for the product
   logic [TMR_W-1:0]    timer, timer_nxt;
   logic                fault_nxt;
   logic                accept_en;
   logic                acc;
   logic [1:0]          acc_val;
`ifdef VEND_CHANGE_EN
   logic                pulse_nxt;
`else
   logic                unused_cancel;
   assign unused_cancel = cancel;
`endif

   assign accept_en = (state == ST_IDLE) || (state == ST_CREDIT);

   coin_arbiter #(
      .CREDIT_MAX (CREDIT_MAX)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .coin_a    (coin_a),
      .coin_b    (coin_b),
      .accept_en (accept_en),
      .credit    (credit),
      .acc       (acc),
      .acc_val   (acc_val),
      .rej_a     (rej_a),
      .rej_b     (rej_b)
   );

   always_comb begin
      state_nxt  = state;
      credit_nxt = credit;
      timer_nxt  = timer;
      fault_nxt  = fault;
`ifdef VEND_CHANGE_EN
      pulse_nxt  = 1'b0;
`endif
      sum = credit + (acc ? {1'b0, acc_val} : {CREDIT_W{1'b0}});
      rem = credit - PRICE;

      case (state)
         ST_IDLE, ST_CREDIT: begin
            // A same-cycle coin is counted before sel/cancel are judged.
            credit_nxt = sum;
            state_nxt  = (sum != '0) ? ST_CREDIT : ST_IDLE;
            if (sel && (sum >= PRICE)) begin
               state_nxt = ST_DISPENSE;
               timer_nxt = '0;
            end
`ifdef VEND_CHANGE_EN
            // cancel overrides sel when both arrive together.
            if (cancel && (sum != '0)) begin
               state_nxt = ST_CHANGE;
            end
`endif
         end

         ST_DISPENSE: begin
            if (disp_ack) begin
               credit_nxt = rem;
`ifdef VEND_CHANGE_EN
               state_nxt  = (rem != '0) ? ST_CHANGE : ST_IDLE;
`else
               state_nxt  = (rem != '0) ? ST_CREDIT : ST_IDLE;
`endif
            end else if (timer == TIMEOUT) begin
               // No ack within the window: flag it and give the money back (or keep it).
               fault_nxt = 1'b1;
`ifdef VEND_CHANGE_EN
               state_nxt = ST_CHANGE;
`else
               state_nxt = ST_CREDIT;
`endif
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end

         ST_CHANGE: begin
`ifdef VEND_CHANGE_EN
            if (credit != '0) begin
               pulse_nxt  = 1'b1;
               credit_nxt = credit - 1'b1;
            end
            // Leave on the same cycle the last unit goes out.
            if (credit <= 1) begin
               state_nxt = ST_IDLE;
            end
`else
            state_nxt = ST_IDLE;
`endif
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         credit   <= '0;
         timer    <= '0;
         fault    <= 1'b0;
         disp_req <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nxt;
         credit   <= credit_nxt;
         timer    <= timer_nxt;
         fault    <= fault_nxt;
         disp_req <= (state_nxt == ST_DISPENSE);
         busy     <= (state_nxt == ST_DISPENSE) || (state_nxt == ST_CHANGE);
      end
   end

`ifdef VEND_CHANGE_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         change_pulse <= 1'b0;
      end else begin
         change_pulse <= pulse_nxt;
      end
   end
`else
   assign change_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_vend_sequencer.sv
// tb_vend_sequencer: directed scenarios plus randomized traffic against a reference model.
// Latency: n/a (testbench).
// Backpressure: n/a.

module tb_vend_sequencer;

   localparam int PRICE       = 3;
   localparam int CREDIT_MAX  = 7;
   localparam int ACK_TIMEOUT = 15;
`ifdef VEND_CHANGE_EN
   localparam bit CHG = 1'b1;
`else
   localparam bit CHG = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] coin_a = 2'b00;
   logic [1:0] coin_b = 2'b00;
   logic       sel = 1'b0, cancel = 1'b0, disp_ack = 1'b0;
   logic       rej_a, rej_b, disp_req, change_pulse, busy, fault;
   logic [2:0] credit;

   always #5 clk = ~clk;

   vend_sequencer #(
      .PRICE_UNITS (PRICE),
      .CREDIT_MAX  (CREDIT_MAX),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .coin_a       (coin_a),
      .coin_b       (coin_b),
      .rej_a        (rej_a),
      .rej_b        (rej_b),
      .sel          (sel),
      .cancel       (cancel),
      .credit       (credit),
      .disp_req     (disp_req),
      .disp_ack     (disp_ack),
      .change_pulse (change_pulse),
      .busy         (busy),
      .fault        (fault)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: money held, whether a dispense is outstanding (and for how long),
   // how much refund is still owed, sticky fault, and which slot wins the next tie.
   int m_cred;
   bit m_disp;
   int m_wait;
   bit m_refund;
   bit m_fault;
   bit m_ptr_a;
   bit e_rej_a, e_rej_b, e_pulse;

   wire [8:0] obs = {rej_a, rej_b, credit, disp_req, change_pulse, busy, fault};

   function automatic int units(input logic [1:0] code);
      if (code == 2'b01) return 1;
      if (code == 2'b10) return 2;
      return 0;
   endfunction

   function automatic logic [8:0] model_vec();
      logic [2:0] c;
      c = 3'(m_cred);
      return {e_rej_a, e_rej_b, c, m_disp, e_pulse, (m_disp | m_refund), m_fault};
   endfunction

   task automatic model_step(input logic [1:0] a, input logic [1:0] b,
                             input logic s, input logic c, input logic k, input logic r);
      int w;
      int v;
      bit ok_a, ok_b;
      if (r) begin
         m_cred = 0; m_disp = 0; m_wait = 0; m_refund = 0; m_fault = 0; m_ptr_a = 1;
         e_rej_a = 0; e_rej_b = 0; e_pulse = 0;
         return;
      end
      e_pulse = 0;
      e_rej_a = (a != 2'b00);
      e_rej_b = (b != 2'b00);
      if (!m_disp && !m_refund) begin
         ok_a = (units(a) > 0);
         ok_b = (units(b) > 0);
         w = 0;
         if (ok_a && ok_b) begin
            w = m_ptr_a ? 1 : 2;
            m_ptr_a = !m_ptr_a;
         end else if (ok_a) begin
            w = 1;
         end else if (ok_b) begin
            w = 2;
         end
         if (w != 0) begin
            v = (w == 1) ? units(a) : units(b);
            if (m_cred + v <= CREDIT_MAX) begin
               m_cred += v;
               if (w == 1) e_rej_a = 0;
               else e_rej_b = 0;
            end
         end
         if (CHG && c && m_cred > 0) begin
            m_refund = 1;
         end else if (s && m_cred >= PRICE) begin
            m_disp = 1;
            m_wait = 0;
         end
      end else if (m_disp) begin
         if (k) begin
            m_cred -= PRICE;
            m_disp = 0;
            if (CHG && m_cred > 0) m_refund = 1;
         end else if (m_wait == ACK_TIMEOUT) begin
            m_fault = 1;
            m_disp = 0;
            if (CHG) m_refund = 1;
         end else begin
            m_wait++;
         end
      end else begin
         e_pulse = 1;
         m_cred--;
         if (m_cred == 0) m_refund = 0;
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, settle, return inputs to idle.
   task automatic tick(input logic [1:0] a, input logic [1:0] b,
                       input logic s, input logic c, input logic k, input logic r);
      coin_a = a; coin_b = b; sel = s; cancel = c; disp_ack = k; rst = r;
      @(posedge clk);
      model_step(a, b, s, c, k, r);
      #1;
      coin_a = 2'b00; coin_b = 2'b00; sel = 0; cancel = 0; disp_ack = 0; rst = 0;
   endtask

   task automatic test_reset();
      tick(2'b10, 2'b01, 1, 1, 1, 1);
      tick(2'b00, 2'b00, 0, 0, 0, 1);
      n_checks++;
      if (obs !== 9'h000) $display("FAIL reset_outputs got=%h want=000", obs);
      else n_pass++;
   endtask

   task automatic test_purchase();
      tick(2'b00, 2'b00, 0, 0, 0, 1);
      tick(2'b10, 2'b00, 0, 0, 0, 0);
      n_checks++;
      if (credit !== 3'd2) $display("FAIL purchase_credit2 got=%0d want=2", credit);
      else n_pass++;
      tick(2'b00, 2'b01, 0, 0, 0, 0);
      n_checks++;
      if (credit !== 3'd3) $display("FAIL purchase_credit3 got=%0d want=3", credit);
      else n_pass++;
      tick(2'b00, 2'b00, 1, 0, 0, 0);
      n_checks++;
      if ({disp_req, busy} !== 2'b11) $display("FAIL purchase_req got=%b want=11", {disp_req, busy});
      else n_pass++;
      tick(2'b00, 2'b00, 0, 0, 0, 0);
      n_checks++;
      if (disp_req !== 1'b1) $display("FAIL purchase_req_held got=%b want=1", disp_req);
      else n_pass++;
      tick(2'b00, 2'b00, 0, 0, 1, 0);
      n_checks++;
      if ({credit, disp_req, change_pulse, busy} !== 6'b000000)
         $display("FAIL purchase_ack got=%b want=000000", {credit, disp_req, change_pulse, busy});
      else n_pass++;
      tick(2'b00, 2'b00, 0, 0, 0, 0);
      n_checks++;
      if (change_pulse !== 1'b0) $display("FAIL purchase_no_change got=%b want=0", change_pulse);
      else n_pass++;
   endtask

   task automatic test_change();
      int pulses;
      tick(2'b00, 2'b00, 0, 0, 0, 1);
      tick(2'b10, 2'b00, 0, 0, 0, 0);
      tick(2'b00, 2'b10, 0, 0, 0, 0);
      tick(2'b01, 2'b00, 1, 0, 0, 0);  // coin counted before the price check
      n_checks++;
      if ({credit, disp_req} !== {3'd5, 1'b1}) $display("FAIL change_sel got=%b want=1011", {credit, disp_req});
      else n_pass++;
      tick(2'b00, 2'b00, 0, 0, 1, 0);
      n_checks++;
      if ({credit, disp_req, busy} !== {3'd2, 1'b0, CHG})
         $display("FAIL change_ack got=%b want=%b", {credit, disp_req, busy}, {3'd2, 1'b0, CHG});
      else n_pass++;
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick(2'b00, 2'b00, 0, 0, 0, 0);
         if (change_pulse === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses !== (CHG ? 2 : 0)) $display("FAIL change_pulses got=%0d want=%0d", pulses, CHG ? 2 : 0);
      else n_pass++;
      n_checks++;
      if (credit !== (CHG ? 3'd0 : 3'd2)) $display("FAIL change_final_credit got=%0d want=%0d", credit, CHG ? 0 : 2);
      else n_pass++;
   endtask

   task automatic test_arbitration();
      tick(2'b00, 2'b00, 0, 0, 0, 1);
      tick(2'b01, 2'b10, 0, 0, 0, 0);
      n_checks++;
      if ({credit, rej_a, rej_b} !== {3'd1, 2'b01}) $display("FAIL arb_first got=%b want=00101", {credit, rej_a, rej_b});
      else n_pass++;
      tick(2'b01, 2'b10, 0, 0, 0, 0);
      n_checks++;
      if ({credit, rej_a, rej_b} !== {3'd3, 2'b10}) $display("FAIL arb_second got=%b want=01110", {credit, rej_a, rej_b});
      else n_pass++;
      tick(2'b01, 2'b01, 0, 0, 0, 0);
      n_checks++;
      if ({credit, rej_a, rej_b} !== {3'd4, 2'b01}) $display("FAIL arb_third got=%b want=10001", {credit, rej_a, rej_b});
      else n_pass++;
   endtask

   task automatic test_overflow();
      tick(2'b00, 2'b00, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) tick(2'b10, 2'b00, 0, 0, 0, 0);
      n_checks++;
      if (credit !== 3'd6) $display("FAIL ovf_fill got=%0d want=6", credit);
      else n_pass++;
      tick(2'b00, 2'b10, 0, 0, 0, 0);
      n_checks++;
      if ({credit, rej_a, rej_b} !== {3'd6, 2'b01}) $display("FAIL ovf_reject got=%b want=11001", {credit, rej_a, rej_b});
      else n_pass++;
      tick(2'b11, 2'b00, 0, 0, 0, 0);
      n_checks++;
      if ({credit, rej_a, rej_b} !== {3'd6, 2'b10}) $display("FAIL bad_code got=%b want=11010", {credit, rej_a, rej_b});
      else n_pass++;
      tick(2'b00, 2'b01, 0, 0, 0, 0);
      n_checks++;
      if ({credit, rej_b} !== {3'd7, 1'b0}) $display("FAIL ovf_to_max got=%b want=1110", {credit, rej_b});
      else n_pass++;
      tick(2'b01, 2'b00, 0, 0, 0, 0);
      n_checks++;
      if ({credit, rej_a} !== {3'd7, 1'b1}) $display("FAIL ovf_at_max got=%b want=1111", {credit, rej_a});
      else n_pass++;
   endtask

   task automatic test_timeout();
      tick(2'b00, 2'b00, 0, 0, 0, 1);
      tick(2'b10, 2'b01, 0, 0, 0, 0);
      tick(2'b01, 2'b00, 1, 0, 0, 0);
      n_checks++;
      if ({credit, disp_req} !== {3'd3, 1'b1}) $display("FAIL tmo_start got=%b want=0111", {credit, disp_req});
      else n_pass++;
      for (int i = 1; i <= ACK_TIMEOUT; i++) begin
         tick(2'b00, 2'b00, 0, 0, 0, 0);
         n_checks++;
         if ({disp_req, fault} !== 2'b10) $display("FAIL tmo_wait cycle=%0d got=%b want=10", i, {disp_req, fault});
         else n_pass++;
      end
      tick(2'b00, 2'b00, 0, 0, 0, 0);
      n_checks++;
      if ({disp_req, fault, credit} !== {2'b01, 3'd3}) $display("FAIL tmo_fault got=%b want=01011", {disp_req, fault, credit});
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         tick(2'b00, 2'b00, 0, 0, 0, 0);
         n_checks++;
         if ({change_pulse, fault} !== {CHG, 1'b1}) $display("FAIL tmo_refund i=%0d got=%b want=%b", i, {change_pulse, fault}, {CHG, 1'b1});
         else n_pass++;
      end
      tick(2'b00, 2'b00, 0, 0, 0, 0);
      n_checks++;
      if ({credit, change_pulse, fault} !== {(CHG ? 3'd0 : 3'd3), 2'b01})
         $display("FAIL tmo_after got=%b want=%b", {credit, change_pulse, fault}, {(CHG ? 3'd0 : 3'd3), 2'b01});
      else n_pass++;
      tick(2'b00, 2'b00, 0, 0, 0, 1);
      n_checks++;
      if (fault !== 1'b0) $display("FAIL tmo_fault_clear got=%b want=0", fault);
      else n_pass++;
   endtask

   task automatic test_cancel_reset();
      tick(2'b00, 2'b00, 0, 0, 0, 1);
      tick(2'b10, 2'b00, 0, 0, 0, 0);
      tick(2'b10, 2'b00, 0, 0, 0, 0);
      tick(2'b00, 2'b00, 1, 1, 0, 0);
      n_checks++;
      if ({disp_req, busy, credit} !== {!CHG, 1'b1, 3'd4})
         $display("FAIL cancel_wins got=%b want=%b", {disp_req, busy, credit}, {!CHG, 1'b1, 3'd4});
      else n_pass++;
      for (int i = 0; i < 2; i++) begin
         tick(2'b00, 2'b00, 0, 0, 0, 0);
         n_checks++;
         if ({change_pulse, disp_req} !== {CHG, !CHG}) $display("FAIL cancel_pulse i=%0d got=%b want=%b", i, {change_pulse, disp_req}, {CHG, !CHG});
         else n_pass++;
      end
      tick(2'b00, 2'b00, 0, 0, 0, 1);
      n_checks++;
      if (obs !== 9'h000) $display("FAIL cancel_rst got=%h want=000", obs);
      else n_pass++;
      tick(2'b00, 2'b00, 0, 0, 0, 0);
      n_checks++;
      if (obs !== 9'h000) $display("FAIL cancel_rst_quiet got=%h want=000", obs);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [1:0] a, b;
      logic s, c, k, r;
      int x;
      int errs;
      errs = 0;
      tick(2'b00, 2'b00, 0, 0, 0, 1);
      for (int i = 0; i < 4000; i++) begin
         x = $urandom_range(0, 9);
         a = (x < 6) ? 2'b00 : (x < 8) ? 2'b01 : (x < 9) ? 2'b10 : 2'b11;
         x = $urandom_range(0, 9);
         b = (x < 6) ? 2'b00 : (x < 8) ? 2'b01 : (x < 9) ? 2'b10 : 2'b11;
         // Ties are only raised while credit can actually be taken.
         if ((m_disp || m_refund) && units(a) > 0 && units(b) > 0) b = 2'b00;
         s = ($urandom_range(0, 5) == 0);
         c = ($urandom_range(0, 11) == 0);
         k = m_disp ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 399) == 0);
         tick(a, b, s, c, k, r);
         n_checks++;
         if (obs !== model_vec()) begin
            if (errs < 10) $display("FAIL random cycle=%0d got=%b want=%b", i, obs, model_vec());
            errs++;
         end else begin
            n_pass++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_purchase();
      test_change();
      test_arbitration();
      test_overflow();
      test_timeout();
      test_cancel_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vend_sequencer.md
# vend_sequencer

Purchase controller for the coin-operated vending datapath. It arbitrates two coin slots onto a single credit accumulator and sequences a priced product dispense through a request/acknowledge handshake. It returns excess credit as 5-unit change pulses. It sits between the coin acceptors and the dispense mechanism, replacing the fixed 15-unit newspaper FSM with a priced, multi-slot sequencer.

## Interface
Parameters:
- PRICE_UNITS, default 3: product price in 5-unit coins (3 = 15).
- CREDIT_MAX, default 7: maximum credit in units. Credit width is 3 bits, so the maximum value of this parameter is 7.
- ACK_TIMEOUT, default 15: cycles that `disp_req` may stay high without an ack before a fault is raised. Range is 1..255.

Ports:
- `clk`  in  1  : sole clock, rising edge.
- `rst`  in  1  : synchronous, active-high reset.
- `coin_a`  in  2  : slot A coin event, valid for one cycle. 00 = none, 01 = 5 (1 unit), 10 = 10 (2 units), 11 = invalid.
- `coin_b`  in  2  : slot B coin event, same encoding as `coin_a`.
- `rej_a`  out  1  : one-cycle pulse; slot A coin was rejected.
- `rej_b`  out  1  : one-cycle pulse; slot B coin was rejected.
- `sel`  in  1  : purchase request, single-cycle pulse.
- `cancel`  in  1  : refund request, single-cycle pulse.
- `credit`  out  3  : current credit in units.
- `disp_req`  out  1  : dispense request, level signal.
- `disp_ack`  in  1  : dispense complete.
- `change_pulse`  out  1  : one cycle high per 1-unit coin returned.
- `busy`  out  1  : high in DISPENSE or CHANGE.
- `fault`  out  1  : sticky dispense-timeout flag.

## Operation
- States are IDLE (credit = 0), CREDIT (credit > 0), DISPENSE and CHANGE. All outputs are registered.
- Reset sets state to IDLE and clears credit, the timer and `fault`. Every output is 0 after reset. The round-robin pointer is reset to favour slot A.
- A coin is accepted only in IDLE or CREDIT. The coin's value is added to credit. The state moves IDLE→CREDIT on the first accepted coin.
- A coin is rejected (rej pulse on its slot) when any of the following holds:
  - its code is 11;
  - the block is in DISPENSE or CHANGE;
  - credit + value > CREDIT_MAX;
  - it lost arbitration.
- When both slots present valid coins in the same cycle, the pointer's slot wins and the other slot is rejected. The pointer then toggles. The pointer toggles only on contention.
- The overflow check applies to the arbitration winner only.
- `sel` with credit ≥ PRICE_UNITS moves the block to DISPENSE. `sel` with credit < PRICE_UNITS is ignored.
- `cancel` in CREDIT moves the block to CHANGE with the full credit. `cancel` in IDLE is ignored.
- `sel` and `cancel` in the same cycle: `cancel` wins.
- A coin arriving in the same cycle as `sel` or `cancel` is added first. The `sel` price check uses the updated credit.
- In DISPENSE, `disp_req` is held high until `disp_ack` is sampled. On ack, credit is reduced by PRICE_UNITS and `disp_req` drops. The next state is CHANGE if the remaining credit is > 0, otherwise IDLE.
- If `disp_ack` has not arrived after ACK_TIMEOUT cycles in DISPENSE, `fault` is set and `disp_req` drops. Credit is not decremented. The block goes to CHANGE, refunding the full credit.
- `fault` is cleared only by `rst`.
- In CHANGE, `change_pulse` is high every cycle and credit decrements by 1 per pulse. The block enters IDLE on the cycle credit reaches 0.
- `disp_ack` is ignored outside DISPENSE.

## Timing
- Coin to `credit` update or rej pulse: 1 cycle.
- `sel` to `disp_req` high: 1 cycle.
- `disp_ack` to `disp_req` low and credit updated: 1 cycle.
- Change of N units: exactly N consecutive `change_pulse` cycles, the first one cycle after entry to CHANGE.
- Timeout: `fault` and `disp_req` low appear on cycle ACK_TIMEOUT+1 after `disp_req` rose.
- `rst` mid-DISPENSE or mid-CHANGE aborts immediately. No further pulses are issued and credit is lost.

## Configuration
- `VEND_CHANGE_EN` defined: the CHANGE state exists, `cancel` is honoured and refunds are issued as described.
- `VEND_CHANGE_EN` undefined:
  - `change_pulse` is tied 0 and `cancel` is ignored.
  - After an ack, the block goes to CREDIT if remaining credit > 0, otherwise IDLE; leftover credit is carried over to the next purchase.
  - A timeout sets `fault`, keeps credit and returns to CREDIT.

## Structure
- Package `vend_pkg` holds:
  - the state enum;
  - the coin codes COIN_NONE, COIN_5, COIN_10, COIN_BAD;
  - the credit width constant (3);
  - a function mapping a coin code to its unit value.
- Sub-module `coin_arbiter` handles validity checks, round-robin selection and rej generation. It outputs the accepted value (0..2) and an accept strobe.
- `vend_sequencer` holds the FSM, credit register and timeout counter.

## Test plan
- Drive `coin_a` = 10 then `coin_b` = 01, then `sel`. Expect credit 2→3, `disp_req` 1 cycle after `sel`; ack → credit 0, IDLE, no `change_pulse`.
- Drive coins summing to 5 units, then `sel` and ack with `VEND_CHANGE_EN`. Expect exactly 2 `change_pulse` cycles, then credit 0.
- Drive `coin_a` = 01 and `coin_b` = 10 in the same cycle, twice. Expect A accepted and `rej_b` first, then B accepted and `rej_a`; credit = 3.
- With credit 6, insert a 10 coin. Expect the matching rej pulse and credit to stay 6. Insert code 11; expect a rej pulse.
- With credit 3, issue `sel` and never ack. Expect `fault` = 1 and `disp_req` low at cycle 16, then 3 change pulses; `fault` holds until `rst`.
- With credit 4, issue `sel` and `cancel` together. Expect 4 change pulses and no `disp_req`. Assert `rst` in the middle of the pulses; pulses stop and all outputs are 0.
